pkt_builder: RTL

//  Consumes {five-tuple, pkt_len} descriptors from the tuple FIFO (fall-through; data valid while !empty)
//  and emits one AXI4-Stream frame per descriptor toward the MAC/output port.

---
 rtl/pktgen_pkg.sv | 36 +++
 rtl/pkt_len_calc.sv | 24 ++
 rtl/pkt_builder.sv | 111 +++++++++++
 3 files changed

// File: rtl/pktgen_pkg.sv
// Shared widths, tuple layout and FSM states for the packet generator datapath,
// plus the beat-formatting helpers used by pkt_builder.
package pktgen_pkg;

  localparam int AXIS_DATA_WIDTH = 256;
  localparam int AXIS_KEEP_WIDTH = 32;
  localparam int AXIS_USER_WIDTH = 128;

  localparam int TUPLE_SRC_IP_LSB = 72;
  localparam int TUPLE_DST_IP_LSB = 40;
  localparam int TUPLE_SPORT_LSB  = 24;
  localparam int TUPLE_DPORT_LSB  = 8;
  localparam int TUPLE_PROTO_LSB  = 0;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;

  // Beat 0: tuple, length and sequence number, all big-endian from byte 0.
  function automatic logic [AXIS_DATA_WIDTH-1:0] head_beat(input logic [103:0] tuple,
                                                           input logic [15:0]  len,
                                                           input logic [31:0]  seq);
    logic [AXIS_DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < 13; k++) d[8*k +: 8] = tuple[103-8*k -: 8];
    d[8*13 +: 8] = len[15:8];
    d[8*14 +: 8] = len[7:0];
    for (int k = 0; k < 4; k++) d[8*(15+k) +: 8] = seq[31-8*k -: 8];
    return d;
  endfunction

  function automatic logic [AXIS_DATA_WIDTH-1:0] body_beat(input int n);
    logic [AXIS_DATA_WIDTH-1:0] d;
    for (int k = 0; k < AXIS_KEEP_WIDTH; k++) d[8*k +: 8] = 8'(32*n + k);
    return d;
  endfunction

endpackage

// File: rtl/pkt_len_calc.sv
// Clamps the requested packet length and derives beat count and last-beat byte mask.
module pkt_len_calc import pktgen_pkg::*; #(
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int BEAT_W  = 6
) (
  input  logic [LEN_W-1:0]           len_i,
  output logic [LEN_W-1:0]           len_o,
  output logic [BEAT_W-1:0]          beats_o,
  output logic [AXIS_KEEP_WIDTH-1:0] last_keep_o
);

  always_comb begin
    len_o = len_i;
    if (len_i < LEN_W'(MIN_LEN))      len_o = LEN_W'(MIN_LEN);
    else if (len_i > LEN_W'(MAX_LEN)) len_o = LEN_W'(MAX_LEN);
    beats_o = BEAT_W'((32'(len_o) + 32'd31) >> 5);
    // A length that fills the last beat exactly keeps every byte.
    if (len_o[4:0] == 5'd0) last_keep_o = '1;
    else                    last_keep_o = (32'd1 << len_o[4:0]) - 32'd1;
  end

endmodule

// File: rtl/pkt_builder.sv
// Turns {five-tuple, length} descriptors from a fall-through FIFO into AXI4-Stream
// test frames: a header beat followed by an incrementing byte pattern.
module pkt_builder import pktgen_pkg::*; #(
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int MIN_PKT_LEN     = 64,
  parameter int MAX_PKT_LEN     = 1518
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     en,
  input  logic [PKT_TUPLE_WIDTH+PKT_LEN_WIDTH-1:0] fifo_data_in,
  input  logic                                     fifo_empty,
  output logic                                     fifo_rd_en,
  output logic [AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]               m_axis_tkeep,
  output logic [AXIS_USER_WIDTH-1:0]               m_axis_tuser,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic                                     m_axis_tlast,
  output logic [31:0]                              pkt_cnt
);

  localparam int MAX_BEATS = (MAX_PKT_LEN + 31) / 32;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

  state_e                     state_q;
  logic [BEAT_W-1:0]          beat_q, beats_q, beat_d;
  logic [AXIS_KEEP_WIDTH-1:0] last_keep_q;
  logic [31:0]                seq_q, pkt_cnt_q;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep_q;
  logic [AXIS_USER_WIDTH-1:0] tuser_q;
  logic                       tvalid_q, tlast_q, last_d, pop;

  logic [PKT_LEN_WIDTH-1:0]   len_l;
  logic [BEAT_W-1:0]          beats_l;
  logic [AXIS_KEEP_WIDTH-1:0] last_keep_l;

  pkt_len_calc #(
    .LEN_W   (PKT_LEN_WIDTH),
    .MIN_LEN (MIN_PKT_LEN),
    .MAX_LEN (MAX_PKT_LEN),
    .BEAT_W  (BEAT_W)
  ) u_len (
    .len_i       (fifo_data_in[PKT_LEN_WIDTH-1:0]),
    .len_o       (len_l),
    .beats_o     (beats_l),
    .last_keep_o (last_keep_l)
  );

  // Fall-through FIFO: the pop is issued in the same cycle the head is captured.
  assign pop    = resetn && (state_q == IDLE) && en && !fifo_empty;
  assign beat_d = beat_q + BEAT_W'(1);
  assign last_d = (beat_d == beats_q - BEAT_W'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      beats_q     <= '0;
      last_keep_q <= '0;
      seq_q       <= '0;
      pkt_cnt_q   <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tuser_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          tdata_q     <= head_beat(fifo_data_in[PKT_LEN_WIDTH +: PKT_TUPLE_WIDTH], len_l, seq_q);
          tkeep_q     <= (beats_l == BEAT_W'(1)) ? last_keep_l : '1;
          tlast_q     <= (beats_l == BEAT_W'(1));
          tuser_q     <= AXIS_USER_WIDTH'(len_l);
          tvalid_q    <= 1'b1;
          beat_q      <= '0;
          beats_q     <= beats_l;
          last_keep_q <= last_keep_l;
          state_q     <= HEAD;
        end
        HEAD, BODY: if (m_axis_tready) begin
          if (tlast_q) begin
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            seq_q     <= seq_q + 32'd1;
            state_q   <= IDLE;
          end else begin
            beat_q  <= beat_d;
            tdata_q <= body_beat(int'(beat_d));
            tkeep_q <= last_d ? last_keep_q : '1;
            tlast_q <= last_d;
            state_q <= BODY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en    = pop;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule
